// File: rtl/nasti_rw_arbiter.sv
// NASTI slave front end: arbitrates AR and AW into one serialized DDR command stream, forwards W beats, returns B.
// Latency: address handshake -> cmd_valid 1 cycle; W beats pass through combinationally; B follows the last beat by 1 cycle.
// Backpressure: one transaction in flight; cmd_ready/wd_ready/b_ready stall the FSM, ar/aw/w ready are low outside their states.
// Optional: define NASTI_ARB_QOS_EN to let the larger aw_qos/ar_qos win simultaneous requests.
module nasti_rw_arbiter #(
  parameter int ID_W       = 9,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [7:0]          aw_len,
  input  logic [3:0]          aw_qos,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  input  logic                w_valid,
  output logic                w_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  output logic                b_valid,
  input  logic                b_ready,
  input  logic [ID_W-1:0]     ar_id,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [7:0]          ar_len,
  input  logic [3:0]          ar_qos,
  input  logic                ar_valid,
  output logic                ar_ready,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_we,
  output logic [ID_W-1:0]     cmd_id,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [7:0]          cmd_len,
  output logic                wd_valid,
  output logic [DATA_W-1:0]   wd_data,
  output logic [DATA_W/8-1:0] wd_strb,
  output logic                wd_last,
  input  logic                wd_ready
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, BRESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t              state, state_nxt;
  logic                last_wr;   // last granted direction, doubles as the preference
  logic [3:0]          streak;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic                we_q;
  logic [7:0]          cnt_q;
  logic                err_q;

  logic                pick_wr;
  logic                grant_rd;
  logic                grant_wr;
  logic                grant;
  logic                cnt_hit;
  logic                w_hs;

`ifndef NASTI_ARB_QOS_EN
  logic                unused_qos;
  assign unused_qos = ^{aw_qos, ar_qos};
`endif

  // Choose the direction to serve when in IDLE.
  always_comb begin
    pick_wr = aw_valid;
    if (ar_valid && aw_valid) begin
      if (streak == STREAK_MAX) begin
        pick_wr = ~last_wr;
      end else begin
        pick_wr = last_wr;
      end
`ifdef NASTI_ARB_QOS_EN
      if (aw_qos > ar_qos) begin
        pick_wr = 1'b1;
      end else if (ar_qos > aw_qos) begin
        pick_wr = 1'b0;
      end
`endif
    end
  end

  assign grant_rd = (state == IDLE) && ar_valid && !pick_wr;
  assign grant_wr = (state == IDLE) && aw_valid && pick_wr;
  assign grant    = grant_rd || grant_wr;
  assign cnt_hit  = (cnt_q == len_q);
  assign w_hs     = (state == WDATA) && w_valid && wd_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and all handshake/datapath outputs, gated by state.
  always_comb begin
    state_nxt = state;
    aw_ready  = 1'b0;
    ar_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_id      = '0;
    b_resp    = 2'b00;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_id    = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wd_valid  = 1'b0;
    wd_data   = '0;
    wd_strb   = '0;
    wd_last   = 1'b0;
    case (state)
      IDLE: begin
        ar_ready = grant_rd;
        aw_ready = grant_wr;
        if (grant) state_nxt = CMD;
      end
      CMD: begin
        cmd_valid = 1'b1;
        cmd_we    = we_q;
        cmd_id    = id_q;
        cmd_addr  = addr_q;
        cmd_len   = len_q;
        if (cmd_ready) state_nxt = we_q ? WDATA : IDLE;
      end
      WDATA: begin
        wd_valid = w_valid;
        w_ready  = wd_ready;
        wd_data  = w_data;
        wd_strb  = w_strb;
        wd_last  = w_last || cnt_hit;
        if (w_hs && (w_last || cnt_hit)) state_nxt = BRESP;
      end
      BRESP: begin
        b_valid = 1'b1;
        b_id    = id_q;
        b_resp  = err_q ? 2'b10 : 2'b00;
        if (b_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant history: streak counts consecutive grants to the same direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= 1'b0;
      streak  <= 4'd0;
    end else if (grant) begin
      if (pick_wr == last_wr) begin
        if (streak != 4'hF) streak <= streak + 4'd1;
      end else begin
        streak  <= 4'd1;
        last_wr <= pick_wr;
      end
    end
  end

  // Capture the granted request; track write beats and protocol errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant) begin
        id_q   <= grant_wr ? aw_id : ar_id;
        addr_q <= grant_wr ? aw_addr : ar_addr;
        len_q  <= grant_wr ? aw_len : ar_len;
        we_q   <= grant_wr;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end
      if (w_hs) begin
        cnt_q <= cnt_q + 8'd1;
        if (w_last != cnt_hit) err_q <= 1'b1;
      end
      if ((state == BRESP) && b_ready) err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nasti_rw_arbiter.sv
// Directed testbench for nasti_rw_arbiter with hand-computed expectations.
// Inputs are driven 1ns after the rising edge and outputs checked 1ns later.
// Each scenario task compares inline and steps total/bad.
module tb_nasti_rw_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  aw_id = '0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [3:0]  aw_qos = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_last = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [8:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [8:0]  ar_id = '0;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [3:0]  ar_qos = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_we;
  logic [8:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_valid;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic        wd_last;
  logic        wd_ready = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nasti_rw_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_qos(aw_qos),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_qos(ar_qos),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_data(wd_data), .wd_strb(wd_strb), .wd_last(wd_last),
    .wd_ready(wd_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b0; cmd_ready = 1'b0; wd_ready = 1'b0;
    aw_qos = '0; ar_qos = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Uncontended write of len+1 well-formed beats, all sinks ready.
  task automatic drive_write(input logic [7:0] len);
    aw_valid = 1'b1; aw_id = 9'h0AA; aw_addr = 32'h2000; aw_len = len;
    cmd_ready = 1'b1; wd_ready = 1'b1; b_ready = 1'b1;
    #1; tick();
    aw_valid = 1'b0;
    tick();
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1; w_last = (i == int'(len)); w_data = 64'(i);
      #1; tick();
    end
    w_valid = 1'b0; w_last = 1'b0;
    #1; tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    #1;
    total++; if (ar_ready !== 1'b0 || aw_ready !== 1'b0 || w_ready !== 1'b0) begin
      bad++; $display("FAIL reset_readies: ar=%b aw=%b w=%b want 000", ar_ready, aw_ready, w_ready); end
    total++; if (cmd_valid !== 1'b0 || b_valid !== 1'b0 || wd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valids: cmd=%b b=%b wd=%b want 000", cmd_valid, b_valid, wd_valid); end
    total++; if (cmd_addr !== 32'h0 || b_resp !== 2'b00 || wd_data !== 64'h0) begin
      bad++; $display("FAIL reset_fields: addr=%h resp=%b wd_data=%h want 0", cmd_addr, b_resp, wd_data); end
  endtask

  task automatic test_single_read();
    cmd_ready = 1'b1;
    ar_valid = 1'b1; ar_id = 9'd5; ar_addr = 32'h1000; ar_len = 8'd3;
    #1;
    total++; if (ar_ready !== 1'b1 || aw_ready !== 1'b0) begin
      bad++; $display("FAIL read_ar_ready: ar=%b aw=%b want 1 0", ar_ready, aw_ready); end
    tick();
    ar_valid = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd_we !== 1'b0 || cmd_len !== 8'd3) begin
      bad++; $display("FAIL read_cmd: valid=%b we=%b len=%0d want 1 0 3", cmd_valid, cmd_we, cmd_len); end
    total++; if (cmd_id !== 9'd5 || cmd_addr !== 32'h1000) begin
      bad++; $display("FAIL read_cmd_fields: id=%0d addr=%h want 5 1000", cmd_id, cmd_addr); end
    tick();
    total++; if (cmd_valid !== 1'b0 || ar_ready !== 1'b0) begin
      bad++; $display("FAIL read_back_idle: cmd_valid=%b ar_ready=%b want 0 0", cmd_valid, ar_ready); end
    idle_inputs();
  endtask

  task automatic test_single_write();
    int beat = 0;
    logic done = 1'b0;
    cmd_ready = 1'b1;
    aw_valid = 1'b1; aw_id = 9'h1A3; aw_addr = 32'h4440; aw_len = 8'd3;
    #1;
    total++; if (aw_ready !== 1'b1 || ar_ready !== 1'b0) begin
      bad++; $display("FAIL write_aw_ready: aw=%b ar=%b want 1 0", aw_ready, ar_ready); end
    tick();
    aw_valid = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd_we !== 1'b1 || cmd_id !== 9'h1A3 || cmd_len !== 8'd3) begin
      bad++; $display("FAIL write_cmd: valid=%b we=%b id=%h len=%0d want 1 1 1a3 3", cmd_valid, cmd_we, cmd_id, cmd_len); end
    tick();
    for (int c = 0; c < 40 && !done; c++) begin
      wd_ready = (c % 2 == 0);
      w_valid = 1'b1;
      w_data = {32'hD0D0_0000, 32'(beat)};
      w_strb = 8'hF0 ^ 8'(beat);
      w_last = (beat == 3);
      #1;
      total++; if (wd_valid !== 1'b1 || w_ready !== wd_ready) begin
        bad++; $display("FAIL write_pass c%0d: wd_valid=%b w_ready=%b want 1 %b", c, wd_valid, w_ready, wd_ready); end
      if (wd_ready) begin
        total++; if (wd_data !== {32'hD0D0_0000, 32'(beat)} || wd_strb !== (8'hF0 ^ 8'(beat)) || wd_last !== (beat == 3)) begin
          bad++; $display("FAIL write_beat%0d: data=%h strb=%h last=%b", beat, wd_data, wd_strb, wd_last); end
        if (beat == 3) done = 1'b1;
        beat++;
      end
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0; wd_ready = 1'b0;
    total++; if (!done) begin
      bad++; $display("FAIL write_timeout: beats=%0d want 4", beat); end
    #1;
    total++; if (b_valid !== 1'b1 || b_resp !== 2'b00 || b_id !== 9'h1A3) begin
      bad++; $display("FAIL write_b: valid=%b resp=%b id=%h want 1 00 1a3", b_valid, b_resp, b_id); end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    #1;
    total++; if (b_valid !== 1'b0) begin
      bad++; $display("FAIL write_b_clear: b_valid=%b want 0", b_valid); end
    idle_inputs();
  endtask

  task automatic test_streak();
    logic exp_wr [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic got_wr [9];
    int n = 0;
    apply_reset();
    ar_valid = 1'b1; ar_len = 8'd0; ar_id = 9'd1;
    aw_valid = 1'b1; aw_len = 8'd0; aw_id = 9'd2;
    w_valid = 1'b1; w_last = 1'b1;
    cmd_ready = 1'b1; wd_ready = 1'b1; b_ready = 1'b1;
    for (int c = 0; c < 80 && n < 9; c++) begin
      #1;
      if (ar_ready === 1'b1) begin got_wr[n] = 1'b0; n++; end
      else if (aw_ready === 1'b1) begin got_wr[n] = 1'b1; n++; end
      tick();
    end
    idle_inputs();
    cmd_ready = 1'b1;
    tick(); tick();
    cmd_ready = 1'b0;
    total++; if (n != 9) begin
      bad++; $display("FAIL streak_timeout: grants=%0d want 9", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (got_wr[i] !== exp_wr[i]) begin
        bad++; $display("FAIL streak_grant%0d: wr=%b want %b", i, got_wr[i], exp_wr[i]); end
    end
  endtask

  task automatic test_wlast_error();
    logic [7:0] lens [2]    = '{8'd3, 8'd1};
    int         last_at [2] = '{1, -1};
    int         exp_n [2]   = '{2, 2};
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      logic done = 1'b0;
      aw_valid = 1'b1; aw_id = 9'(20 + k); aw_len = lens[k];
      cmd_ready = 1'b1; wd_ready = 1'b1;
      #1; tick();
      aw_valid = 1'b0;
      tick();
      for (int c = 0; c < 10 && !done; c++) begin
        w_valid = 1'b1; w_last = (c == last_at[k]);
        #1;
        total++; if (wd_last !== (c == exp_n[k] - 1)) begin
          bad++; $display("FAIL err%0d_wd_last beat%0d: got %b want %b", k, c, wd_last, (c == exp_n[k] - 1)); end
        if (wd_last === 1'b1) done = 1'b1;
        n++;
        tick();
      end
      w_valid = 1'b0; w_last = 1'b0;
      #1;
      total++; if (n != exp_n[k] || b_valid !== 1'b1 || b_resp !== 2'b10) begin
        bad++; $display("FAIL err%0d_b: beats=%0d valid=%b resp=%b want %0d 1 10", k, n, b_valid, b_resp, exp_n[k]); end
      b_ready = 1'b1;
      tick();
      idle_inputs();
    end
  endtask

  task automatic test_reset_midburst();
    logic saw_b = 1'b0;
    aw_valid = 1'b1; aw_id = 9'd9; aw_len = 8'd7;
    cmd_ready = 1'b1; wd_ready = 1'b1;
    #1; tick();
    aw_valid = 1'b0;
    tick();
    w_valid = 1'b1; w_data = 64'h11;
    #1; tick();
    w_data = 64'h22;
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (wd_valid !== 1'b0 || w_ready !== 1'b0 || wd_data !== 64'h0 || wd_last !== 1'b0) begin
      bad++; $display("FAIL rst_mid_wd: wd_valid=%b w_ready=%b data=%h last=%b want 0", wd_valid, w_ready, wd_data, wd_last); end
    total++; if (cmd_valid !== 1'b0 || b_valid !== 1'b0 || aw_ready !== 1'b0 || ar_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid_ctl: cmd=%b b=%b aw=%b ar=%b want 0", cmd_valid, b_valid, aw_ready, ar_ready); end
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
    b_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (b_valid !== 1'b0) saw_b = 1'b1;
      tick();
    end
    b_ready = 1'b0;
    total++; if (saw_b) begin
      bad++; $display("FAIL rst_no_b: b_valid seen=%b want 0", saw_b); end
    cmd_ready = 1'b1;
    ar_valid = 1'b1; ar_id = 9'd7; ar_addr = 32'h3000; ar_len = 8'd0;
    #1;
    total++; if (ar_ready !== 1'b1) begin
      bad++; $display("FAIL rst_read_ar: ar_ready=%b want 1", ar_ready); end
    tick();
    ar_valid = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd_we !== 1'b0 || cmd_id !== 9'd7) begin
      bad++; $display("FAIL rst_read_cmd: valid=%b we=%b id=%0d want 1 0 7", cmd_valid, cmd_we, cmd_id); end
    tick();
    #1;
    total++; if (cmd_valid !== 1'b0) begin
      bad++; $display("FAIL rst_read_idle: cmd_valid=%b want 0", cmd_valid); end
    idle_inputs();
  endtask

  task automatic test_qos();
    logic exp_rd;
`ifdef NASTI_ARB_QOS_EN
    exp_rd = 1'b1;
`else
    exp_rd = 1'b0;
`endif
    drive_write(8'd0);
    aw_valid = 1'b1; aw_id = 9'd30; aw_len = 8'd0; aw_qos = 4'd2;
    ar_valid = 1'b1; ar_id = 9'd31; ar_len = 8'd0; ar_qos = 4'd9;
    cmd_ready = 1'b0;
    #1;
    total++; if (ar_ready !== exp_rd || aw_ready !== !exp_rd) begin
      bad++; $display("FAIL qos_grant: ar=%b aw=%b want %b %b", ar_ready, aw_ready, exp_rd, !exp_rd); end
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd_we !== !exp_rd) begin
      bad++; $display("FAIL qos_cmd: valid=%b we=%b want 1 %b", cmd_valid, cmd_we, !exp_rd); end
    idle_inputs();
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single_read();
    test_single_write();
    test_streak();
    test_wlast_error();
    test_reset_midburst();
    test_qos();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nasti_rw_arbiter.md
Name: nasti_rw_arbiter

Overview:
- NASTI slave-side front end of the DDR memory controller.
- Takes read (AR) and write (AW/W/B) requests from the slave modport of the system NASTI interface.
- Arbitrates them into a single serialized command stream for the DDR scheduler and forwards write beats.
- Generates the B response. R channel is outside this block (the DDR read datapath returns it directly).

Parameters:
- ID_W, 9, NASTI id width
- ADDR_W, 32, NASTI address width
- DATA_W, 64, NASTI data width; strobe width is DATA_W/8
- MAX_STREAK, 4, max consecutive grants to one direction while the other direction is pending; legal range 1..15

Ports:
- clk  in  1  controller clock
- rst_n  in  1  asynchronous active-low reset
- aw_id/aw_addr/aw_len/aw_qos  in  ID_W/ADDR_W/8/4  write address fields
- aw_valid  in  1
- aw_ready  out  1
- w_data/w_strb/w_last/w_valid  in  DATA_W/DATA_W/8/1/1  write data
- w_ready  out  1
- b_id  out  ID_W
- b_resp  out  2
- b_valid  out  1
- b_ready  in  1
- ar_id/ar_addr/ar_len/ar_qos  in  ID_W/ADDR_W/8/4  read address fields
- ar_valid  in  1
- ar_ready  out  1
- cmd_valid  out  1  command to DDR scheduler
- cmd_ready  in  1
- cmd_we  out  1  1 = write
- cmd_id/cmd_addr/cmd_len  out  ID_W/ADDR_W/8  captured request fields
- wd_valid/wd_data/wd_strb/wd_last  out  1/DATA_W/DATA_W/8/1  write beats to scheduler
- wd_ready  in  1

Behaviour:
- Reset values: all outputs 0, state IDLE, preference READ, streak 0, beat count 0. Reset mid-burst abandons the transaction; no B is issued for it.
- FSM states: IDLE, CMD, WDATA, BRESP.
- IDLE, grant selection:
  - Only ar_valid: grant read. Only aw_valid: grant write.
  - Both valid: grant the preferred direction, unless streak==MAX_STREAK, in which case grant the other direction.
- IDLE, grant action:
  - Assert the granted ready combinationally in the same cycle as its valid (exactly one of ar_ready/aw_ready high).
  - Capture id/addr/len and cmd_we, then go to CMD.
  - Streak: if the granted direction equals the last granted direction, streak saturating-increments; otherwise streak resets to 1 and the last granted direction updates.
- CMD: cmd_valid=1 with fields stable. On cmd_ready, go to IDLE (read) or WDATA (write). Minimum latency is 1 cycle from address handshake to cmd_valid.
- WDATA:
  - Combinational pass-through: wd_valid=w_valid, w_ready=wd_ready, wd_data/wd_strb=w_data/w_strb.
  - 8-bit beat counter increments on each w handshake.
  - wd_last = w_last OR (count==cmd_len).
  - On the handshake where wd_last=1, go to BRESP.
  - Error flag is set if w_last and (count==cmd_len) disagree: early w_last ends the burst early; a missing w_last is force-terminated at beat len+1.
- BRESP: b_valid=1, b_id=captured id, b_resp=2'b00 OKAY or 2'b10 SLVERR if error flag set. On b_ready, go to IDLE and clear the flag.
- aw_ready, ar_ready, w_ready are 0 outside their states. No new address is accepted until the current transaction completes (one outstanding transaction).
- aw_len=255 gives 256 beats; the counter must not wrap before termination.

Optional Feature:
- Macro: NASTI_ARB_QOS_EN.
- Defined: when both directions are valid in IDLE, the larger qos wins outright. Equal qos falls back to the preference/streak rule. A qos-based grant still updates streak.
- Undefined: aw_qos/ar_qos are ignored and arbitration is preference/streak only.

Test Plan:
- Single read, ar_id=5, addr=0x1000, len=3, cmd_ready held 1 -> ar_ready same cycle; cmd_valid next cycle with cmd_we=0, len=3; back in IDLE the cycle after.
- Single write, len=3, 4 beats with w_last on beat 4, wd_ready toggling 1/0 -> 4 wd beats with matching data/strb, wd_last on beat 4 only; b_valid with b_resp=00, b_id=aw_id.
- ar_valid and aw_valid held continuously, MAX_STREAK=4, cmd_ready=1 -> grant order R,R,R,R,W,W,W,W,R…; no direction is ever granted 5 in a row.
- Write len=3 with w_last on beat 2 -> burst ends after 2 beats, b_resp=10. Write len=1 with w_last never asserted -> wd_last forced on beat 2, b_resp=10.
- rst_n pulsed low during WDATA beat 2 of a len=7 write -> all outputs 0 asynchronously, no b_valid afterwards; next read completes normally.
- With NASTI_ARB_QOS_EN, simultaneous aw_qos=2 and ar_qos=9 while preference is write -> read granted first. Same stimulus without the macro -> write granted first.
